vga_fb_scheduler: RTL

- Schedules a single-port synchronous framebuffer RAM between the VGA scan-out and one pixel writer (drawing engine or CPU).
- Runs on CLOCK_50; the pixel clock is CLOCK_50/2, so each pixel period has two CLOCK_50 slots. The display read owns the slot on pix_tick; the writer gets the remaining slots and all of blanking.
- Upscales the framebuffer by 2^SCALE_LOG2 and drives the red/green/blue inputs of the VGA timing block from its next_x/next_y outputs.

---
 rtl/vga_fb_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/vga_fb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : vga_fb_scheduler
// Purpose  : Shares one single-port synchronous framebuffer RAM between the
//            VGA scan-out and a single pixel writer. Display reads own the
//            pix_tick slot of each pixel period. The writer gets every other
//            slot and all of blanking. The framebuffer is upscaled by
//            2^SCALE_LOG2 on scan-out.
// Ports    : CLOCK_50/reset_n       - clock, async active-low reset
//            pix_tick,next_x,next_y - scan position from the VGA timing block
//            red/green/blue         - registered pixel back to the timing block
//            wr_valid/wr_ready      - writer handshake (wr_ready combinational)
//            wr_x/wr_y/wr_data      - framebuffer coordinate and pixel value
//            vblank_only            - restrict writer to vertical blanking
//            mem_addr/we/wdata/rdata- RAM port (rdata one cycle after addr)
//            frame_start            - one-cycle pulse after the (0,0) tick
//            drop_count             - saturating count of out-of-range writes
// Revision : 1.0 - initial release
// ============================================================================
module vga_fb_scheduler #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 24
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              pix_tick,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  output logic [7:0]        red,
  output logic [7:0]        green,
  output logic [7:0]        blue,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [9:0]        wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              vblank_only,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_start,
  output logic [15:0]       drop_count
);

  localparam int               c_fb_w     = H_ACTIVE >> SCALE_LOG2;
  localparam int               c_fb_h     = V_ACTIVE >> SCALE_LOG2;
  localparam logic [9:0]       c_h_active = 10'(H_ACTIVE);
  localparam logic [9:0]       c_v_active = 10'(V_ACTIVE);
  localparam logic [9:0]       c_fb_w10   = 10'(c_fb_w);
  localparam logic [9:0]       c_fb_h10   = 10'(c_fb_h);
  localparam logic [ADDR_W-1:0] c_fb_w_a  = ADDR_W'(c_fb_w);

  // Slot decision for the current cycle; the registered copy doubles as the
  // read-pending flag (DISP last cycle means read data arrives this cycle).
  typedef enum logic [0:0] {
    SLOT_FREE = 1'b0,
    SLOT_DISP = 1'b1
  } slot_t;

  slot_t               r_slot;
  slot_t               w_slot;
  logic                w_active;
  logic                w_vblank;
  logic [ADDR_W-1:0]   w_disp_addr;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic                w_wr_in_range;
  logic                w_drop;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_blank;
  logic [DATA_W-1:0]   r_rgb;
  logic                r_frame_start;
  logic [15:0]         r_drop_count;

  // Coordinates are unsigned, so an underflowed (wrapped) next_x lands far
  // above H_ACTIVE and counts as blanking without special handling.
  assign w_active      = (next_x < c_h_active) && (next_y < c_v_active);
  assign w_vblank      = (next_y >= c_v_active);
  assign w_disp_addr   = ADDR_W'(next_y >> SCALE_LOG2) * c_fb_w_a
                       + ADDR_W'(next_x >> SCALE_LOG2);
  assign w_wr_addr     = ADDR_W'(wr_y) * c_fb_w_a + ADDR_W'(wr_x);
  assign w_wr_in_range = (wr_x < c_fb_w10) && (wr_y < c_fb_h10);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_slot <= SLOT_FREE;
    end else begin
      r_slot <= w_slot;
    end
  end

  // RAM port outputs are combinational so the RAM samples the decision made
  // in this very cycle. While reset is held nothing may reach the RAM.
  always_comb begin
    w_slot    = SLOT_FREE;
    wr_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = r_addr;
    mem_wdata = '0;
    w_drop    = 1'b0;
    if (reset_n) begin
      if (pix_tick && w_active) begin
        w_slot   = SLOT_DISP;
        mem_addr = w_disp_addr;
      end else begin
        wr_ready = ~vblank_only | w_vblank;
        if (wr_valid && wr_ready) begin
          if (w_wr_in_range) begin
            mem_we    = 1'b1;
            mem_addr  = w_wr_addr;
            mem_wdata = wr_data;
          end else begin
            w_drop = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_addr        <= '0;
      r_blank       <= 1'b0;
      r_rgb         <= '0;
      r_frame_start <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      // Remember the last driven address so idle cycles leave it unchanged.
      r_addr        <= mem_addr;
      r_blank       <= pix_tick & ~w_active;
      r_frame_start <= pix_tick & (next_x == 10'd0) & (next_y == 10'd0);
      if (r_slot == SLOT_DISP) begin
        r_rgb <= mem_rdata;
      end else if (r_blank) begin
        r_rgb <= '0;
      end
      if (w_drop && (r_drop_count != 16'hFFFF)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign red         = r_rgb[23:16];
  assign green       = r_rgb[15:8];
  assign blue        = r_rgb[7:0];
  assign frame_start = r_frame_start;
  assign drop_count  = r_drop_count;

endmodule
`default_nettype wire
